// File: rtl/rename_status_table_pkg.sv
// rst_pkg: shared defaults and the rename status entry type
package rst_pkg;
   localparam int DEF_NREG  = 32;
   localparam int DEF_ROBW  = 3;
   localparam int DEF_NLANE = 2;
   localparam int DEF_NCMT  = 2;
   localparam int DEF_NCKPT = 4;
   typedef struct packed {
      logic                busy;
      logic [DEF_ROBW-1:0] tag;
   } status_entry_t;
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/rename_status_table_if.sv
// rename_status_table_if: rename, commit and checkpoint signals of the status table
interface rename_status_table_if
   import rst_pkg::*;
#(
   parameter int NREG  = DEF_NREG,
   parameter int ROBW  = DEF_ROBW,
   parameter int NLANE = DEF_NLANE,
   parameter int NCMT  = DEF_NCMT,
   parameter int NCKPT = DEF_NCKPT
);
   localparam int RW = idx_w(NREG);
   localparam int LW = idx_w(NLANE);
   localparam int CW = idx_w(NCKPT);
   logic [NLANE-1:0]           ren_valid;
   logic [NLANE-1:0][RW-1:0]   ren_rd, ren_rs1, ren_rs2;
   logic [NLANE-1:0][ROBW-1:0] ren_rob;
   logic [NLANE-1:0]           src1_busy, src2_busy;
   logic [NLANE-1:0][ROBW-1:0] src1_rob, src2_rob;
   logic [NCMT-1:0]            cmt_valid;
   logic [NCMT-1:0][RW-1:0]    cmt_rd;
   logic [NCMT-1:0][ROBW-1:0]  cmt_rob;
   logic                       ckpt_take;
   logic [LW-1:0]              ckpt_lane;
   logic [CW-1:0]              ckpt_id;
   logic                       ckpt_full;
   logic                       ckpt_release;
   logic                       restore;
   logic [CW-1:0]              restore_id;
   logic                       flush;
   modport master (
      output ren_valid, ren_rd, ren_rs1, ren_rs2, ren_rob, cmt_valid, cmt_rd, cmt_rob,
             ckpt_take, ckpt_lane, ckpt_release, restore, restore_id, flush,
      input  src1_busy, src2_busy, src1_rob, src2_rob, ckpt_id, ckpt_full
   );
   modport slave (
      input  ren_valid, ren_rd, ren_rs1, ren_rs2, ren_rob, cmt_valid, cmt_rd, cmt_rob,
             ckpt_take, ckpt_lane, ckpt_release, restore, restore_id, flush,
      output src1_busy, src2_busy, src1_rob, src2_rob, ckpt_id, ckpt_full
   );
endinterface

// File: rtl/rename_status_table_ckpt.sv
// status_ckpt_buf: circular FIFO of table snapshots kept current by commits
module status_ckpt_buf
   import rst_pkg::*;
#(
   parameter int NREG  = DEF_NREG,
   parameter int ROBW  = DEF_ROBW,
   parameter int NCMT  = DEF_NCMT,
   parameter int NCKPT = DEF_NCKPT
)
(
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               flush,
   input  logic                               ckpt_take,
   input  logic                               ckpt_release,
   input  logic                               restore,
   input  logic [idx_w(NCKPT)-1:0]            restore_id,
   input  logic [NREG-1:0]                    snap_busy,
   input  logic [NREG-1:0][ROBW-1:0]          snap_tag,
   input  logic [NCMT-1:0]                    cmt_valid,
   input  logic [NCMT-1:0][idx_w(NREG)-1:0]   cmt_rd,
   input  logic [NCMT-1:0][ROBW-1:0]          cmt_rob,
   output logic [idx_w(NCKPT)-1:0]            ckpt_id,
   output logic                               ckpt_full,
   output logic [NREG-1:0]                    rd_busy,
   output logic [NREG-1:0][ROBW-1:0]          rd_tag
);
   localparam int RW = idx_w(NREG);
   localparam int CW = idx_w(NCKPT);
   localparam int NW = $clog2(NCKPT + 1);
   logic [NCKPT-1:0][NREG-1:0]           busy, cbusy;
   logic [NCKPT-1:0][NREG-1:0][ROBW-1:0] tag;
   logic [CW-1:0]                        head, tail, roff, rdist;
   logic [NW-1:0]                        count;
   logic                                 take_ok, rel_ok;
   // a commit clears every slot whose entry for its rd still names its tag
   always_comb begin
      cbusy = busy;
      for (int s = 0; s < NCKPT; s++)
         for (int r = 0; r < NREG; r++)
            for (int c = 0; c < NCMT; c++)
               if (cmt_valid[c] && cmt_rd[c] == RW'(r) && cmt_rob[c] == tag[s][r]) cbusy[s][r] = 1'b0;
   end
   assign ckpt_full = count == NW'(NCKPT);
   assign ckpt_id   = tail;
   assign take_ok   = ckpt_take && !restore && (!ckpt_full || ckpt_release);
   assign rel_ok    = ckpt_release && count != '0 && !(restore && restore_id == head);
   assign roff      = restore_id - head;
   assign rdist     = restore_id - head - CW'(rel_ok);
   assign rd_busy   = cbusy[restore_id];
   assign rd_tag    = tag[restore_id];
   // slot storage: snapshot lands at the tail, other slots track commits
   always_ff @(posedge clk)
      if (reset) begin
         busy <= '0;
         tag  <= '0;
      end else if (flush) busy <= '0;
      else begin
         busy <= cbusy;
         if (take_ok) begin
            busy[tail] <= snap_busy;
            tag[tail]  <= snap_tag;
         end
      end
   // head/tail/count; a restore trims the tail back to the restored slot
   always_ff @(posedge clk)
      if (reset || flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         head <= head + CW'(rel_ok);
         if (restore) begin
            assert (NW'(roff) < count);
            tail  <= restore_id;
            count <= NW'(rdist);
         end else begin
            tail  <= tail + CW'(take_ok);
            count <= count + NW'(take_ok) - NW'(rel_ok);
         end
      end
endmodule

// File: rtl/rename_status_table.sv
// rename_status_table: live register busy/tag table with same-cycle rename bypass
module rename_status_table
   import rst_pkg::*;
#(
   parameter int NREG  = DEF_NREG,
   parameter int ROBW  = DEF_ROBW,
   parameter int NLANE = DEF_NLANE,
   parameter int NCMT  = DEF_NCMT,
   parameter int NCKPT = DEF_NCKPT
)
(
   input logic                  clk,
   input logic                  reset,
   rename_status_table_if.slave bus
);
   localparam int RW = idx_w(NREG);
   localparam int LW = idx_w(NLANE);
   logic [NREG-1:0]            busy, cbusy, nbusy, sbusy, rbusy;
   logic [NREG-1:0][ROBW-1:0]  tag, ntag, stag, rtag;
   logic [NLANE-1:0]           s1b, s2b;
   logic [NLANE-1:0][ROBW-1:0] s1t, s2t;
   // commits clear first, then renames in lane order so the youngest lane wins
   always_comb begin
      cbusy = busy;
      for (int r = 0; r < NREG; r++)
         for (int c = 0; c < NCMT; c++)
            if (bus.cmt_valid[c] && bus.cmt_rd[c] == RW'(r) && bus.cmt_rob[c] == tag[r]) cbusy[r] = 1'b0;
      nbusy = cbusy;
      ntag  = tag;
      sbusy = cbusy;
      stag  = tag;
      for (int l = 0; l < NLANE; l++)
         if (bus.ren_valid[l] && bus.ren_rd[l] != '0) begin
            nbusy[bus.ren_rd[l]] = 1'b1;
            ntag[bus.ren_rd[l]]  = bus.ren_rob[l];
            if (LW'(l) <= bus.ckpt_lane) begin
               sbusy[bus.ren_rd[l]] = 1'b1;
               stag[bus.ren_rd[l]]  = bus.ren_rob[l];
            end
         end
   end
   // source lookup: youngest older lane renaming the register beats the table
   always_comb begin
      for (int i = 0; i < NLANE; i++) begin
         s1b[i] = cbusy[bus.ren_rs1[i]];
         s1t[i] = tag[bus.ren_rs1[i]];
         s2b[i] = cbusy[bus.ren_rs2[i]];
         s2t[i] = tag[bus.ren_rs2[i]];
         for (int j = 0; j < NLANE; j++)
            if (j < i && bus.ren_valid[j] && bus.ren_rd[j] != '0) begin
               if (bus.ren_rd[j] == bus.ren_rs1[i]) begin
                  s1b[i] = 1'b1;
                  s1t[i] = bus.ren_rob[j];
               end
               if (bus.ren_rd[j] == bus.ren_rs2[i]) begin
                  s2b[i] = 1'b1;
                  s2t[i] = bus.ren_rob[j];
               end
            end
      end
   end
   assign bus.src1_busy = s1b;
   assign bus.src1_rob  = s1t;
   assign bus.src2_busy = s2b;
   assign bus.src2_rob  = s2t;
   status_ckpt_buf #(.NREG(NREG), .ROBW(ROBW), .NCMT(NCMT), .NCKPT(NCKPT)) u_ckpt (
      .clk          (clk),
      .reset        (reset),
      .flush        (bus.flush),
      .ckpt_take    (bus.ckpt_take),
      .ckpt_release (bus.ckpt_release),
      .restore      (bus.restore),
      .restore_id   (bus.restore_id),
      .snap_busy    (sbusy),
      .snap_tag     (stag),
      .cmt_valid    (bus.cmt_valid),
      .cmt_rd       (bus.cmt_rd),
      .cmt_rob      (bus.cmt_rob),
      .ckpt_id      (bus.ckpt_id),
      .ckpt_full    (bus.ckpt_full),
      .rd_busy      (rbusy),
      .rd_tag       (rtag)
   );
   // live table: reset, then flush, then restore, then normal update
   always_ff @(posedge clk)
      if (reset) begin
         busy <= '0;
         tag  <= '0;
      end else if (bus.flush) busy <= '0;
      else if (bus.restore) begin
         busy <= rbusy;
         tag  <= rtag;
      end else begin
         busy <= nbusy;
         tag  <= ntag;
      end
endmodule

// File: tb/tb_rename_status_table.sv
// tb_rename_status_table: directed and randomized checks against a rule-level model
module tb_rename_status_table;
   localparam int NREG = 32, ROBW = 3, NLANE = 2, NCMT = 2, NCKPT = 4;
   localparam int RW = $clog2(NREG);
   logic clk = 1'b0;
   logic reset = 1'b1;
   int vectors = 0, miscompares = 0;
   bit m_busy [NREG];
   int m_tag  [NREG];
   bit k_busy [NCKPT][NREG];
   int k_tag  [NCKPT][NREG];
   int head = 0, tail = 0, cnt = 0;

   rename_status_table_if #(.NREG(NREG), .ROBW(ROBW), .NLANE(NLANE), .NCMT(NCMT), .NCKPT(NCKPT)) bus ();
   rename_status_table #(.NREG(NREG), .ROBW(ROBW), .NLANE(NLANE), .NCMT(NCMT), .NCKPT(NCKPT)) dut (
      .clk(clk), .reset(reset), .bus(bus.slave));

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0d expected=%0d", name, obs, exp);
      end
   endtask

   task automatic idle();
      bus.ren_valid = '0; bus.ren_rd = '0; bus.ren_rs1 = '0; bus.ren_rs2 = '0; bus.ren_rob = '0;
      bus.cmt_valid = '0; bus.cmt_rd = '0; bus.cmt_rob = '0;
      bus.ckpt_take = 1'b0; bus.ckpt_lane = '0; bus.ckpt_release = 1'b0;
      bus.restore = 1'b0; bus.restore_id = '0; bus.flush = 1'b0;
   endtask

   task automatic ren(input int l, input int rd, input int rob);
      bus.ren_valid[l] = 1'b1; bus.ren_rd[l] = RW'(rd); bus.ren_rob[l] = ROBW'(rob);
   endtask

   task automatic look(input int l, input int a, input int b);
      bus.ren_rs1[l] = RW'(a); bus.ren_rs2[l] = RW'(b);
   endtask

   task automatic cmt(input int c, input int rd, input int rob);
      bus.cmt_valid[c] = 1'b1; bus.cmt_rd[c] = RW'(rd); bus.cmt_rob[c] = ROBW'(rob);
   endtask

   // expected lookup: an older lane renaming s this cycle, else the model entry minus matching commits
   task automatic expect_src(input int i, input int s, output int eb, output int et);
      eb = m_busy[s] ? 1 : 0;
      et = m_tag[s];
      for (int c = 0; c < NCMT; c++)
         if (bus.cmt_valid[c] && int'(bus.cmt_rd[c]) == s && int'(bus.cmt_rob[c]) == m_tag[s]) eb = 0;
      for (int j = 0; j < i; j++)
         if (bus.ren_valid[j] && s != 0 && int'(bus.ren_rd[j]) == s) begin
            eb = 1;
            et = int'(bus.ren_rob[j]);
         end
   endtask

   task automatic settle();
      int eb, et;
      #1;
      for (int i = 0; i < NLANE; i++) begin
         expect_src(i, int'(bus.ren_rs1[i]), eb, et);
         check($sformatf("src1_busy[%0d]", i), 32'(bus.src1_busy[i]), eb);
         check($sformatf("src1_rob[%0d]", i), 32'(bus.src1_rob[i]), et);
         expect_src(i, int'(bus.ren_rs2[i]), eb, et);
         check($sformatf("src2_busy[%0d]", i), 32'(bus.src2_busy[i]), eb);
         check($sformatf("src2_rob[%0d]", i), 32'(bus.src2_rob[i]), et);
      end
      check("ckpt_id", 32'(bus.ckpt_id), tail);
      check("ckpt_full", 32'(bus.ckpt_full), 32'(cnt == NCKPT));
   endtask

   // advance the model by one clock from the currently driven inputs, then clock the DUT
   task automatic tick();
      bit cb [NREG];
      bit kb [NCKPT][NREG];
      int rel, take, rid, r, t;
      if (reset) begin
         foreach (m_busy[i]) begin m_busy[i] = 0; m_tag[i] = 0; end
         foreach (k_busy[k, i]) begin k_busy[k][i] = 0; k_tag[k][i] = 0; end
         head = 0; tail = 0; cnt = 0;
      end else if (bus.flush) begin
         foreach (m_busy[i]) m_busy[i] = 0;
         head = 0; tail = 0; cnt = 0;
      end else begin
         cb = m_busy;
         kb = k_busy;
         for (int c = 0; c < NCMT; c++)
            if (bus.cmt_valid[c]) begin
               r = int'(bus.cmt_rd[c]);
               t = int'(bus.cmt_rob[c]);
               if (m_tag[r] == t) cb[r] = 0;
               for (int k = 0; k < NCKPT; k++) if (k_tag[k][r] == t) kb[k][r] = 0;
            end
         rel = (bus.ckpt_release && cnt > 0 && !(bus.restore && int'(bus.restore_id) == head)) ? 1 : 0;
         k_busy = kb;
         if (bus.restore) begin
            rid = int'(bus.restore_id);
            m_busy = kb[rid];
            m_tag = k_tag[rid];
            head = (head + rel) % NCKPT;
            tail = rid;
            cnt = (rid - head + NCKPT) % NCKPT;
         end else begin
            take = (bus.ckpt_take && (cnt < NCKPT || bus.ckpt_release)) ? 1 : 0;
            m_busy = cb;
            for (int l = 0; l < NLANE; l++) begin
               if (bus.ren_valid[l] && bus.ren_rd[l] != 0) begin
                  m_busy[int'(bus.ren_rd[l])] = 1;
                  m_tag[int'(bus.ren_rd[l])] = int'(bus.ren_rob[l]);
               end
               if (take == 1 && l == int'(bus.ckpt_lane)) begin
                  k_busy[tail] = m_busy;
                  k_tag[tail] = m_tag;
               end
            end
            tail = (tail + take) % NCKPT;
            cnt = cnt + take - rel;
            head = (head + rel) % NCKPT;
         end
      end
      @(posedge clk);
      @(negedge clk);
      idle();
   endtask

   initial begin
      idle();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      look(0, 5, 7); look(1, 9, 1);
      settle();
      check("reset ckpt_id", 32'(bus.ckpt_id), 0);
      check("reset ckpt_full", 32'(bus.ckpt_full), 0);
      check("reset r5 busy", 32'(bus.src1_busy[0]), 0);
      tick();
      // same-cycle bypass from lane 0 to lane 1
      ren(0, 5, 3); look(1, 5, 0);
      settle();
      check("bypass busy", 32'(bus.src1_busy[1]), 1);
      check("bypass rob", 32'(bus.src1_rob[1]), 3);
      tick();
      look(0, 5, 5);
      settle();
      check("r5 busy", 32'(bus.src1_busy[0]), 1);
      check("r5 tag", 32'(bus.src1_rob[0]), 3);
      tick();
      // commit and rename on the same register
      ren(0, 7, 2);
      settle();
      tick();
      cmt(0, 7, 2); ren(0, 7, 4); look(0, 7, 0);
      settle();
      check("r7 lookup with commit", 32'(bus.src1_busy[0]), 0);
      tick();
      look(0, 7, 0);
      settle();
      check("r7 busy after rename", 32'(bus.src1_busy[0]), 1);
      check("r7 tag after rename", 32'(bus.src1_rob[0]), 4);
      tick();
      // stale commit leaves the younger writer in place
      cmt(0, 7, 2);
      settle();
      tick();
      look(0, 7, 0);
      settle();
      check("r7 stale commit busy", 32'(bus.src1_busy[0]), 1);
      check("r7 stale commit tag", 32'(bus.src1_rob[0]), 4);
      tick();
      // fill, overfill, take+release while full
      reset = 1'b1; tick(); reset = 1'b0;
      for (int k = 0; k < 4; k++) begin bus.ckpt_take = 1'b1; settle(); tick(); end
      settle();
      check("full after 4", 32'(bus.ckpt_full), 1);
      check("id wraps after 4", 32'(bus.ckpt_id), 0);
      bus.ckpt_take = 1'b1;
      settle();
      tick();
      settle();
      check("fifth take ignored id", 32'(bus.ckpt_id), 0);
      bus.ckpt_take = 1'b1; bus.ckpt_release = 1'b1;
      settle();
      tick();
      settle();
      check("take+release id", 32'(bus.ckpt_id), 1);
      check("take+release full", 32'(bus.ckpt_full), 1);
      tick();
      // restore to a checkpoint whose entry was committed afterwards
      reset = 1'b1; tick(); reset = 1'b0;
      bus.ckpt_take = 1'b1; settle(); tick();
      ren(0, 9, 5); bus.ckpt_take = 1'b1; bus.ckpt_lane = '0; settle(); tick();
      cmt(0, 9, 5); settle(); tick();
      ren(0, 9, 6); settle(); tick();
      bus.restore = 1'b1; bus.restore_id = 2'd1; settle(); tick();
      look(0, 9, 9);
      settle();
      check("restored r9 busy", 32'(bus.src1_busy[0]), 0);
      check("restored r9 tag", 32'(bus.src1_rob[0]), 5);
      check("restore tail", 32'(bus.ckpt_id), 1);
      tick();
      for (int k = 0; k < 3; k++) begin bus.ckpt_take = 1'b1; settle(); tick(); end
      settle();
      check("restore count 1 then 3 takes full", 32'(bus.ckpt_full), 1);
      tick();
      // flush with live checkpoints and busy registers
      reset = 1'b1; tick(); reset = 1'b0;
      for (int r = 1; r <= 10; r++) begin
         ren(0, r, r % 8);
         bus.ckpt_take = (r % 3 == 0);
         settle();
         tick();
      end
      bus.flush = 1'b1; ren(0, 20, 1); cmt(0, 3, 3); bus.ckpt_take = 1'b1;
      settle();
      tick();
      for (int r = 0; r < NREG; r += 4) begin
         look(0, r, r + 1); look(1, r + 2, r + 3);
         settle();
         check("flushed busy a", 32'(bus.src1_busy[0] | bus.src2_busy[0]), 0);
         check("flushed busy b", 32'(bus.src1_busy[1] | bus.src2_busy[1]), 0);
         tick();
      end
      settle();
      check("flush ckpt_full", 32'(bus.ckpt_full), 0);
      check("flush ckpt_id", 32'(bus.ckpt_id), 0);
      tick();
      // reset on top of a restore
      ren(0, 4, 6); bus.ckpt_take = 1'b1; settle(); tick();
      bus.ckpt_take = 1'b1; settle(); tick();
      bus.restore = 1'b1; bus.restore_id = 2'd0; reset = 1'b1;
      settle();
      tick();
      reset = 1'b0;
      look(0, 4, 4);
      settle();
      check("reset in restore busy", 32'(bus.src1_busy[0]), 0);
      check("reset in restore tag", 32'(bus.src1_rob[0]), 0);
      check("reset in restore id", 32'(bus.ckpt_id), 0);
      tick();
      // randomized traffic over a small register window
      for (int n = 0; n < 800; n++) begin
         int r;
         for (int l = 0; l < NLANE; l++) begin
            if ($urandom_range(3) != 0) ren(l, $urandom_range(7), $urandom_range(7));
            look(l, $urandom_range(7), $urandom_range(7));
         end
         for (int c = 0; c < NCMT; c++)
            if ($urandom_range(2) == 0) begin
               r = $urandom_range(7);
               cmt(c, r, $urandom_range(1) ? m_tag[r] : $urandom_range(7));
            end
         bus.ckpt_take = ($urandom_range(3) == 0);
         bus.ckpt_lane = 1'($urandom_range(NLANE - 1));
         bus.ckpt_release = ($urandom_range(5) == 0);
         if (cnt > 0 && $urandom_range(9) == 0) begin
            bus.restore = 1'b1;
            bus.restore_id = 2'((head + $urandom_range(cnt - 1)) % NCKPT);
            if (int'(bus.restore_id) == head) bus.ckpt_release = 1'b0;
         end
         bus.flush = ($urandom_range(49) == 0);
         reset = ($urandom_range(149) == 0);
         settle();
         tick();
      end
      reset = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
